// File: rtl/cam_pixel_capture.sv
// Sensor-clock capture stage: packs RGB565 byte pairs into RGB444 pixel writes, framed by vsync.
// Optional 2:1 downscale in both axes when CAM_DECIMATE_EN is defined.
module cam_pixel_capture #(
  parameter int ADDR_W       = 19,
  parameter int FRAME_PIXELS = 307200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic              wen,
  output logic [ADDR_W-1:0] addr,
  output logic [11:0]       dout,
  output logic              frame_done,
  output logic              overflow
);

  typedef enum logic [1:0] {SYNC_WAIT, VBLANK, ACTIVE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  state_t              state_reg, state_next;
  logic                phase_reg, phase_next;
  logic [7:0]          b0_reg, b0_next;
  logic                vsync_q_reg;
  logic                full_reg, full_next;
  logic                wen_reg, wen_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [11:0]         dout_reg, dout_next;
  logic                frame_done_reg, frame_done_next;
  logic                overflow_reg, overflow_next;
  logic [11:0]         pix_word;
  logic                keep;

`ifdef CAM_DECIMATE_EN
  logic parity_reg, parity_next;
  logic pix_reg, pix_next;
  logic href_q_reg;
`endif

  assign pix_word = {b0_reg[7:4], b0_reg[2:0], d[7], d[4:1]};

`ifdef CAM_DECIMATE_EN
  assign keep = ~parity_reg & ~pix_reg;
`else
  assign keep = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= SYNC_WAIT;
      phase_reg      <= 1'b0;
      b0_reg         <= 8'd0;
      vsync_q_reg    <= 1'b0;
      full_reg       <= 1'b0;
      wen_reg        <= 1'b0;
      addr_reg       <= '0;
      dout_reg       <= 12'd0;
      frame_done_reg <= 1'b0;
      overflow_reg   <= 1'b0;
`ifdef CAM_DECIMATE_EN
      parity_reg     <= 1'b0;
      pix_reg        <= 1'b0;
      href_q_reg     <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      phase_reg      <= phase_next;
      b0_reg         <= b0_next;
      vsync_q_reg    <= vsync;
      full_reg       <= full_next;
      wen_reg        <= wen_next;
      addr_reg       <= addr_next;
      dout_reg       <= dout_next;
      frame_done_reg <= frame_done_next;
      overflow_reg   <= overflow_next;
`ifdef CAM_DECIMATE_EN
      parity_reg     <= parity_next;
      pix_reg        <= pix_next;
      href_q_reg     <= href;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    phase_next      = phase_reg;
    b0_next         = b0_reg;
    full_next       = full_reg;
    wen_next        = 1'b0;
    addr_next       = addr_reg;
    dout_next       = dout_reg;
    frame_done_next = 1'b0;
    overflow_next   = overflow_reg;
`ifdef CAM_DECIMATE_EN
    parity_next     = parity_reg;
    pix_next        = pix_reg;
`endif

    case (state_reg)
      SYNC_WAIT: begin
        if (vsync) state_next = VBLANK;
      end

      VBLANK: begin
        addr_next     = '0;
        phase_next    = 1'b0;
        full_next     = 1'b0;
        overflow_next = 1'b0;
`ifdef CAM_DECIMATE_EN
        parity_next   = 1'b0;
        pix_next      = 1'b0;
`endif
        if (!vsync) state_next = ACTIVE;
      end

      ACTIVE: begin
        if (vsync) begin
          // Any byte arriving with the vsync rise is abandoned along with the frame.
          state_next      = VBLANK;
          frame_done_next = ~vsync_q_reg;
        end else begin
          // Advance one cycle after the write; the last slot latches "full" instead of wrapping.
          if (wen_reg) begin
            if (addr_reg == LAST_ADDR) full_next = 1'b1;
            else                       addr_next = addr_reg + 1'b1;
          end

          if (href) begin
            if (!phase_reg) begin
              b0_next    = d;
              phase_next = 1'b1;
            end else begin
              phase_next = 1'b0;
`ifdef CAM_DECIMATE_EN
              pix_next   = ~pix_reg;
`endif
              if (keep) begin
                if (full_reg) begin
                  overflow_next = 1'b1;
                end else begin
                  wen_next  = 1'b1;
                  dout_next = pix_word;
                end
              end
            end
          end else begin
            phase_next = 1'b0;
`ifdef CAM_DECIMATE_EN
            pix_next   = 1'b0;
            if (href_q_reg) parity_next = ~parity_reg;
`endif
          end
        end
      end

      default: state_next = SYNC_WAIT;
    endcase
  end

  assign wen        = wen_reg;
  assign addr       = addr_reg;
  assign dout       = dout_reg;
  assign frame_done = frame_done_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Directed bench for cam_pixel_capture with a 4-pixel frame buffer so the overflow boundary is
// reachable; define CAM_DECIMATE_EN on both files to exercise the downscale path.
module tb_cam_pixel_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        vsync;
  logic        href;
  logic [7:0]  d;
  logic        wen;
  logic [18:0] addr;
  logic [11:0] dout;
  logic        frame_done;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int fd_cnt   = 0;
  logic [18:0] wa[$];
  logic [11:0] wd[$];

  cam_pixel_capture #(.ADDR_W(19), .FRAME_PIXELS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .href       (href),
    .d          (d),
    .wen        (wen),
    .addr       (addr),
    .dout       (dout),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Record every write and frame_done pulse half a cycle after the edge that produced it.
  always @(negedge clk) begin
    if (reset && wen) begin
      wa.push_back(addr);
      wd.push_back(dout);
    end
    if (reset && frame_done) fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step(input logic v, input logic h, input logic [7:0] dd);
    vsync = v;
    href  = h;
    d     = dd;
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input logic [7:0] b0, input logic [7:0] b1);
    step(1'b0, 1'b1, b0);
    step(1'b0, 1'b1, b1);
  endtask

  task automatic vblank();
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic clr();
    wa.delete();
    wd.delete();
    fd_cnt = 0;
  endtask

  initial begin
    reset = 1'b0;
    vsync = 1'b0;
    href  = 1'b0;
    d     = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wen", wen, 1'b0);
    check("rst_addr", addr, 19'd0);
    check("rst_dout", dout, 12'h000);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    reset = 1'b1;

    // First pixel of a frame, then asynchronous reset in the middle of the frame.
    vblank();
    pixel(8'hF8, 8'h1F);
    check("t1_wen", wen, 1'b1);
    check("t1_addr", addr, 19'd0);
    check("t1_dout", dout, 12'hF0F);
    step(1'b0, 1'b0, 8'h00);
    check("t1_addr_inc", addr, 19'd1);
    reset = 1'b0;
    #1;
    check("t1_async_addr", addr, 19'd0);
    check("t1_async_dout", dout, 12'h000);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // After reset, a stream with vsync held low must not be captured.
    clr();
    for (int i = 0; i < 4; i++) pixel(8'h12, 8'h34);
    idle(2);
    check("t1_no_wen", wa.size(), 0);
    vblank();
    pixel(8'hF8, 8'h1F);
    idle(2);
    check("t1_resume_cnt", wa.size(), 1);
    check("t1_resume_addr", wa[0], 19'd0);

    // Two lines of four pixels each.
    vblank();
    clr();
    for (int l = 0; l < 2; l++) begin
      pixel(8'hF8, 8'h1F);
      pixel(8'h00, 8'hFF);
      pixel(8'h12, 8'h34);
      pixel(8'hAB, 8'hCD);
      idle(2);
    end
    idle(2);
`ifdef CAM_DECIMATE_EN
    check("t6_cnt", wa.size(), 2);
    check("t6_addr0", wa[0], 19'd0);
    check("t6_dout0", wd[0], 12'hF0F);
    check("t6_addr1", wa[1], 19'd1);
    check("t6_dout1", wd[1], 12'h14A);
    check("t6_overflow", overflow, 1'b0);
`else
    check("t6_cnt", wa.size(), 4);
    check("t6_addr3", wa[3], 19'd3);
    check("t6_dout1", wd[1], 12'h01F);
    check("t6_dout3", wd[3], 12'hA76);
    check("t6_overflow", overflow, 1'b1);
`endif

`ifndef CAM_DECIMATE_EN
    // Back-to-back pixels, a dangling odd byte, then overflow of the 4-pixel frame.
    vblank();
    clr();
    pixel(8'hF8, 8'h1F);
    pixel(8'h00, 8'hFF);
    step(1'b0, 1'b1, 8'hAB);
    step(1'b0, 1'b1, 8'hCD);
    step(1'b0, 1'b1, 8'hEF);
    idle(2);
    pixel(8'h12, 8'h34);
    idle(2);
    check("t2_cnt", wa.size(), 4);
    check("t2_addr0", wa[0], 19'd0);
    check("t2_dout0", wd[0], 12'hF0F);
    check("t2_addr1", wa[1], 19'd1);
    check("t2_dout1", wd[1], 12'h01F);
    check("t3_addr2", wa[2], 19'd2);
    check("t3_dout2", wd[2], 12'hA76);
    check("t3_addr3", wa[3], 19'd3);
    check("t3_dout3", wd[3], 12'h14A);
    check("t4_no_ovf_yet", overflow, 1'b0);
    pixel(8'h55, 8'h66);
    pixel(8'h77, 8'h88);
    idle(2);
    check("t4_cnt", wa.size(), 4);
    check("t4_overflow", overflow, 1'b1);
    check("t4_addr_hold", addr, 19'd3);
    check("t4_dout_hold", dout, 12'h14A);
    step(1'b1, 1'b0, 8'h00);
    check("t4_frame_done", frame_done, 1'b1);
    step(1'b1, 1'b0, 8'h00);
    check("t4_fd_one_cycle", frame_done, 1'b0);
    check("t4_ovf_cleared", overflow, 1'b0);
    step(1'b1, 1'b0, 8'h00);
    check("t4_fd_cnt", fd_cnt, 1);

    // Second byte arrives together with the vsync rise.
    idle(2);
    clr();
    pixel(8'hF8, 8'h1F);
    step(1'b0, 1'b1, 8'h55);
    step(1'b1, 1'b1, 8'h1F);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check("t5_cnt", wa.size(), 1);
    check("t5_fd_cnt", fd_cnt, 1);
    idle(2);
    pixel(8'h12, 8'h34);
    idle(2);
    check("t5_next_cnt", wa.size(), 2);
    check("t5_next_addr", wa[1], 19'd0);
    check("t5_next_dout", wd[1], 12'h14A);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
